// File: rtl/hash_round_controller.sv
// Sequencing FSM for the H[0..7] hash register file: takes message bytes over a
// valid/ready stream, counts the message length, and drives the init/update/finalize strobes.
module hash_round_controller #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             msg_valid,
  input  logic [7:0]       msg_byte,
  input  logic             msg_last,
  output logic             msg_ready,
  output logic [7:0]       byte_out,
  output logic [0:7][7:0]  C_byte,
  output logic             init_H,
  output logic             update_H,
  output logic [2:0]       i_count,
  output logic             sel_final,
  output logic             busy,
  output logic             digest_valid
);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    ROUND,
    WAIT_BYTE,
    FINAL,
    DONE
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   count;
  logic               last_q;
  logic               accept;

  assign accept = msg_valid & msg_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      byte_out <= '0;
      last_q   <= 1'b0;
      i_count  <= '0;
    end else begin
      state <= state_next;
      if (state == ROUND || state == FINAL)
        i_count <= i_count + 3'd1;
      if (accept) begin
        byte_out <= msg_byte;
        last_q   <= msg_last;
        i_count  <= '0;
        // The first byte of a message restarts the length count.
        count    <= (state == IDLE) ? CNT_W'(1) : count + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (accept) state_next = INIT;
      INIT:      state_next = ROUND;
      ROUND:     if (i_count == 3'd7) state_next = last_q ? FINAL : WAIT_BYTE;
      WAIT_BYTE: if (accept) state_next = ROUND;
      FINAL:     if (i_count == 3'd7) state_next = DONE;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    msg_ready    = (state == IDLE) || (state == WAIT_BYTE);
    busy         = (state != IDLE);
    init_H       = (state == INIT);
    update_H     = (state == ROUND) || (state == FINAL);
    sel_final    = (state == FINAL);
    digest_valid = (state == DONE);
  end

  // Bytes beyond the configured counter width read as zero.
  for (genvar k = 0; k < 8; k++) begin : g_cbyte
    if (k < CNT_W / 8) begin : g_live
      assign C_byte[k] = count[8*k +: 8];
    end else begin : g_zero
      assign C_byte[k] = '0;
    end
  end

endmodule

// File: tb/tb_hash_round_controller.sv
// Bench for hash_round_controller: three instances (64/16/8-bit counters) share one
// input stream and are compared cycle by cycle against a per-cycle expected schedule.
module tb_hash_round_controller;

  logic clk = 1'b0;
  logic reset, msg_valid, msg_last;
  logic [7:0] msg_byte;

  logic            rdy [3];
  logic            bsy [3];
  logic            ini [3];
  logic            upd [3];
  logic            sel [3];
  logic            dv  [3];
  logic [7:0]      bo  [3];
  logic [2:0]      ic  [3];
  logic [0:7][7:0] cb  [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hash_round_controller #(.CNT_W(64)) u64 (
    .clk(clk), .reset(reset), .msg_valid(msg_valid), .msg_byte(msg_byte), .msg_last(msg_last),
    .msg_ready(rdy[0]), .byte_out(bo[0]), .C_byte(cb[0]), .init_H(ini[0]), .update_H(upd[0]),
    .i_count(ic[0]), .sel_final(sel[0]), .busy(bsy[0]), .digest_valid(dv[0]));
  hash_round_controller #(.CNT_W(16)) u16 (
    .clk(clk), .reset(reset), .msg_valid(msg_valid), .msg_byte(msg_byte), .msg_last(msg_last),
    .msg_ready(rdy[1]), .byte_out(bo[1]), .C_byte(cb[1]), .init_H(ini[1]), .update_H(upd[1]),
    .i_count(ic[1]), .sel_final(sel[1]), .busy(bsy[1]), .digest_valid(dv[1]));
  hash_round_controller #(.CNT_W(8)) u8 (
    .clk(clk), .reset(reset), .msg_valid(msg_valid), .msg_byte(msg_byte), .msg_last(msg_last),
    .msg_ready(rdy[2]), .byte_out(bo[2]), .C_byte(cb[2]), .init_H(ini[2]), .update_H(upd[2]),
    .i_count(ic[2]), .sel_final(sel[2]), .busy(bsy[2]), .digest_valid(dv[2]));

  // One entry per clock cycle: inputs to drive and outputs expected in that cycle.
  typedef struct packed {
    bit              v;
    logic [7:0]      b;
    bit              l;
    bit              rdy, busy, init, upd, sel, dv;
    logic [2:0]      i;
    logic [7:0]      bo;
    longint unsigned cnt;
    int              bidx;
  } ent_t;

  ent_t              sq[$];
  logic [7:0]        mb[$];
  int                ms[$];
  longint unsigned   model_cnt = 0;
  logic [7:0]        last_bo   = 8'h00;

  function automatic int width_of(int d);
    return (d == 0) ? 64 : (d == 1) ? 16 : 8;
  endfunction

  function automatic logic [0:7][7:0] exp_cb(longint unsigned c, int w);
    logic [0:7][7:0] r;
    for (int k = 0; k < 8; k++)
      r[k] = (k < w / 8) ? 8'(c >> (8 * k)) : 8'h00;
    return r;
  endfunction

  function automatic ent_t noise(ent_t e, bit glitch);
    ent_t r = e;
    if (glitch) begin
      r.v = 1'($urandom_range(0, 1));
      r.b = 8'($urandom);
      r.l = 1'($urandom_range(0, 1));
    end
    return r;
  endfunction

  // Expected timeline of a message from mb/ms: INIT, 8 rounds per byte with optional
  // WAIT_BYTE stalls between bytes, 8 finalization steps, one DONE cycle.
  task automatic build(input bit glitch);
    ent_t e;
    longint unsigned c;
    int n = mb.size();
    sq.delete();
    e = '0; e.v = 1; e.b = mb[0]; e.l = (n == 1); e.rdy = 1; e.bo = last_bo;
    e.cnt = model_cnt; e.bidx = -1; sq.push_back(e);
    c = 1;
    e = '0; e.init = 1; e.busy = 1; e.bo = mb[0]; e.cnt = c; e.bidx = -1;
    sq.push_back(noise(e, glitch));
    for (int j = 0; j < n; j++) begin
      if (j > 0) begin
        for (int s = 0; s < ms[j]; s++) begin
          e = '0; e.rdy = 1; e.busy = 1; e.bo = mb[j-1]; e.cnt = c; e.bidx = -1;
          sq.push_back(e);
        end
        e = '0; e.rdy = 1; e.busy = 1; e.bo = mb[j-1]; e.cnt = c; e.bidx = -1;
        e.v = 1; e.b = mb[j]; e.l = (j == n - 1);
        sq.push_back(e);
        c++;
      end
      for (int i = 0; i < 8; i++) begin
        e = '0; e.busy = 1; e.upd = 1; e.i = 3'(i); e.bo = mb[j]; e.cnt = c; e.bidx = j;
        sq.push_back(noise(e, glitch));
      end
    end
    for (int i = 0; i < 8; i++) begin
      e = '0; e.busy = 1; e.upd = 1; e.sel = 1; e.i = 3'(i); e.bo = mb[n-1]; e.cnt = c; e.bidx = -1;
      sq.push_back(noise(e, glitch));
    end
    e = '0; e.busy = 1; e.dv = 1; e.bo = mb[n-1]; e.cnt = c; e.bidx = -1;
    sq.push_back(noise(e, glitch));
    model_cnt = c;
    last_bo   = mb[n-1];
  endtask

  task automatic play(input int n);
    for (int k = 0; k < n; k++) begin
      ent_t e = sq[k];
      for (int d = 0; d < 3; d++) begin
        logic [5:0] os = {rdy[d], bsy[d], ini[d], upd[d], sel[d], dv[d]};
        logic [5:0] es = {e.rdy, e.busy, e.init, e.upd, e.sel, e.dv};
        logic [0:7][7:0] ec = exp_cb(e.cnt, width_of(d));
        checks++;
        if (os !== es) begin
          failures++;
          $display("FAIL strobes dut%0d step%0d got=%b want=%b (rdy,busy,init,upd,sel,dv)", d, k, os, es);
        end
        checks++;
        if (bo[d] !== e.bo) begin
          failures++;
          $display("FAIL byte_out dut%0d step%0d got=%h want=%h", d, k, bo[d], e.bo);
        end
        checks++;
        if (cb[d] !== ec) begin
          failures++;
          $display("FAIL C_byte dut%0d step%0d got=%h want=%h", d, k, cb[d], ec);
        end
        if (e.upd) begin
          checks++;
          if (ic[d] !== e.i) begin
            failures++;
            $display("FAIL i_count dut%0d step%0d got=%0d want=%0d", d, k, ic[d], e.i);
          end
        end
      end
      msg_valid = e.v;
      msg_byte  = e.b;
      msg_last  = e.l;
      @(negedge clk);
    end
    msg_valid = 1'b0;
  endtask

  task automatic load_msg(input int n, input int max_stall);
    mb.delete();
    ms.delete();
    for (int j = 0; j < n; j++) begin
      mb.push_back(8'($urandom));
      ms.push_back((j == 0) ? 0 : $urandom_range(0, max_stall));
    end
  endtask

  task automatic check_idle(input string tag);
    for (int d = 0; d < 3; d++) begin
      logic [7:0] os = {rdy[d], bsy[d], ini[d], upd[d], sel[d], dv[d], cb[d] == '0, bo[d] == 8'h00};
      checks++;
      if (os !== 8'b1000_0011) begin
        failures++;
        $display("FAIL %s dut%0d got=%b want=10000011 (rdy,busy,init,upd,sel,dv,cnt0,bo0)", tag, d, os);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; msg_valid = 1'b0; msg_byte = 8'h00; msg_last = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset_hold");
    reset = 1'b0;
    @(negedge clk);
    check_idle("reset_idle");
    model_cnt = 0;
    last_bo   = 8'h00;
  endtask

  task automatic test_single_byte;
    mb.delete(); ms.delete();
    mb.push_back(8'h41); ms.push_back(0);
    build(1'b0);
    play(sq.size());
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (cb[d] !== exp_cb(64'd1, 64)) begin
        failures++;
        $display("FAIL single_cbyte dut%0d got=%h want=01 then zeros", d, cb[d]);
      end
    end
  endtask

  task automatic test_three_byte;
    mb.delete(); ms.delete();
    mb.push_back(8'h10); ms.push_back(0);
    mb.push_back(8'h20); ms.push_back(5);
    mb.push_back(8'h30); ms.push_back(0);
    build(1'b1);
    play(sq.size());
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (cb[d][0] !== 8'h03) begin
        failures++;
        $display("FAIL three_cbyte0 dut%0d got=%h want=03", d, cb[d][0]);
      end
    end
  endtask

  task automatic test_random_messages;
    repeat (5) begin
      load_msg($urandom_range(1, 6), 4);
      build(1'b1);
      play(sq.size());
    end
  endtask

  task automatic test_back_to_back;
    repeat (2) begin
      load_msg($urandom_range(2, 3), 0);
      build(1'b0);
      play(sq.size());
    end
  endtask

  task automatic test_wrap;
    load_msg(256, 0);
    build(1'b1);
    play(sq.size());
    checks++;
    if (cb[0][0] !== 8'h00 || cb[0][1] !== 8'h01) begin
      failures++;
      $display("FAIL wrap64 got=%h%h want=0100", cb[0][1], cb[0][0]);
    end
    checks++;
    if (cb[2] !== '0) begin
      failures++;
      $display("FAIL wrap8 got=%h want=0", cb[2]);
    end
  endtask

  task automatic test_cnt16;
    load_msg(300, 0);
    build(1'b0);
    play(sq.size());
    checks++;
    if (cb[1][0] !== 8'h2C || cb[1][1] !== 8'h01 || cb[1][2:7] !== '0) begin
      failures++;
      $display("FAIL cnt16_300 got=%h want=2c01000000000000", cb[1]);
    end
  endtask

  task automatic test_reset_mid_message;
    int p = -1;
    load_msg(3, 2);
    build(1'b1);
    for (int k = 0; k < sq.size(); k++)
      if (p < 0 && sq[k].upd && !sq[k].sel && sq[k].bidx == 1 && sq[k].i == 3'd4) p = k;
    play(p);
    checks++;
    if (upd[0] !== 1'b1 || ic[0] !== 3'd4) begin
      failures++;
      $display("FAIL pre_reset_round got upd=%b i=%0d want upd=1 i=4", upd[0], ic[0]);
    end
    reset = 1'b1;
    msg_valid = 1'b0;
    @(negedge clk);
    check_idle("mid_reset");
    reset = 1'b0;
    model_cnt = 0;
    last_bo   = 8'h00;
    for (int t = 0; t < 20; t++) begin
      checks++;
      if (dv[0] !== 1'b0 || bsy[0] !== 1'b0) begin
        failures++;
        $display("FAIL post_reset_quiet cycle%0d got dv=%b busy=%b want 0 0", t, dv[0], bsy[0]);
      end
      @(negedge clk);
    end
    load_msg(1, 0);
    build(1'b0);
    play(sq.size());
  endtask

  initial begin
    reset = 1'b1; msg_valid = 1'b0; msg_byte = 8'h00; msg_last = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_byte();
    test_three_byte();
    test_random_messages();
    test_back_to_back();
    test_wrap();
    test_reset_mid_message();
    test_cnt16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
